rf_writeback_queue: RTL and testbench

RF_WRITEBACK_QUEUE -- requirements
Module: rf_writeback_queue

---
 rtl/rf_writeback_queue.sv | 133 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
// Small circular FIFO that buffers register-file writebacks and drains one
// entry per cycle onto the write port (we3/a3/wd3) unless hold is high.
// Writes to r0 are acknowledged and dropped.
// Optional feature macro: RF_WB_BYPASS_EN. When defined, the a1/a2 read
// addresses are looked up against pending entries and the youngest matching
// value is presented on fwdN_data. When undefined, the fwd outputs are 0.
module rf_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_data,
   input  logic        hold,
   output logic        we3,
   output logic [4:0]  a3,
   output logic [31:0] wd3,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   output logic        fwd1_hit,
   output logic        fwd2_hit,
   output logic [31:0] fwd1_data,
   output logic [31:0] fwd2_data,
   output logic [4:0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [4:0]    FULL_COUNT = 5'(DEPTH);

   logic [4:0]    rd_mem_r   [DEPTH];
   logic [31:0]   data_mem_r [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [4:0]    count_r;
   logic          push_s;
   logic          pop_s;

   // Ready depends only on the registered count, so a pop on the same edge
   // does not open a slot for a full queue.
   assign in_ready = (count_r != FULL_COUNT);
   assign we3      = (count_r != 5'd0) && !hold;
   assign push_s   = in_valid && in_ready && (in_rd != 5'd0);
   assign pop_s    = we3;
   assign count    = count_r;

   // Present the head entry on the write port, zero when empty.
   always_comb begin
      a3  = 5'd0;
      wd3 = 32'd0;
      if (count_r != 5'd0) begin
         a3  = rd_mem_r[head_r];
         wd3 = data_mem_r[head_r];
      end else begin
         a3  = 5'd0;
         wd3 = 32'd0;
      end
   end

   // Pointer and occupancy state; storage validity derives from these only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= 5'd0;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_ONE;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 5'd1;
            2'b01:   count_r <= count_r - 5'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage is not reset; it is only meaningful under count/pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         rd_mem_r[tail_r]   <= in_rd;
         data_mem_r[tail_r] <= in_data;
      end
   end

`ifdef RF_WB_BYPASS_EN
   logic        fwd1_hit_s;
   logic        fwd2_hit_s;
   logic [31:0] fwd1_data_s;
   logic [31:0] fwd2_data_s;

   // Scan pending entries oldest to youngest so the youngest match wins.
   always_comb begin
      fwd1_hit_s  = 1'b0;
      fwd2_hit_s  = 1'b0;
      fwd1_data_s = 32'd0;
      fwd2_data_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         logic          live;
         logic          m1;
         logic          m2;
         idx  = head_r + PW'(i);
         live = (5'(i) < count_r);
         m1   = live && (a1 != 5'd0) && (rd_mem_r[idx] == a1);
         m2   = live && (a2 != 5'd0) && (rd_mem_r[idx] == a2);
         fwd1_hit_s  = fwd1_hit_s | m1;
         fwd2_hit_s  = fwd2_hit_s | m2;
         fwd1_data_s = m1 ? data_mem_r[idx] : fwd1_data_s;
         fwd2_data_s = m2 ? data_mem_r[idx] : fwd2_data_s;
      end
   end

   assign fwd1_hit  = fwd1_hit_s;
   assign fwd2_hit  = fwd2_hit_s;
   assign fwd1_data = fwd1_data_s;
   assign fwd2_data = fwd2_data_s;
`else
   logic unused_addr_s;
   assign unused_addr_s = ^{a1, a2};
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = 32'd0;
   assign fwd2_data = 32'd0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue (DEPTH = 4).
// Expected values are hand-computed per scenario.
module tb_rf_writeback_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        hold;
   logic        we3;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic        fwd1_hit;
   logic        fwd2_hit;
   logic [31:0] fwd1_data;
   logic [31:0] fwd2_data;
   logic [4:0]  count;

   int tests_run;
   int tests_failed;

   rf_writeback_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .hold      (hold),
      .we3       (we3),
      .a3        (a3),
      .wd3       (wd3),
      .a1        (a1),
      .a2        (a2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data),
      .count     (count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are stable 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      in_valid = 1'b1;
      in_rd    = rd;
      in_data  = data;
      tick();
      in_valid = 1'b0;
      in_rd    = 5'd0;
      in_data  = 32'd0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_rd    = 5'd0;
      in_data  = 32'd0;
      hold     = 1'b0;
      a1       = 5'd0;
      a2       = 5'd0;

      // Reset state
      #12;
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_we3", 32'(we3), 32'd0);
      check_eq("rst_a3", 32'(a3), 32'd0);
      check_eq("rst_wd3", 32'(wd3), 32'd0);
      check_eq("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single push, one-cycle drain; no in_* -> we3 path
      in_valid = 1'b1;
      in_rd    = 5'd5;
      in_data  = 32'h11;
      #1;
      check_eq("s1_we3_before_edge", 32'(we3), 32'd0);
      tick();
      in_valid = 1'b0;
      in_rd    = 5'd0;
      in_data  = 32'd0;
      check_eq("s1_we3", 32'(we3), 32'd1);
      check_eq("s1_a3", 32'(a3), 32'd5);
      check_eq("s1_wd3", wd3, 32'h11);
      check_eq("s1_count", 32'(count), 32'd1);
      tick();
      check_eq("s1_we3_after", 32'(we3), 32'd0);
      check_eq("s1_count_after", 32'(count), 32'd0);

      // Fill under hold, reject when full, drain in order
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         push(5'(i), 32'hA0 + 32'(i));
      end
      check_eq("s2_count_full", 32'(count), 32'd4);
      check_eq("s2_in_ready_full", 32'(in_ready), 32'd0);
      check_eq("s2_we3_held", 32'(we3), 32'd0);
      push(5'd6, 32'hB6);
      check_eq("s2_count_rejected", 32'(count), 32'd4);
      check_eq("s2_a3_head", 32'(a3), 32'd1);
      // Full with a pop on the same edge: offer still refused
      in_valid = 1'b1;
      in_rd    = 5'd6;
      in_data  = 32'hB6;
      hold     = 1'b0;
      #1;
      check_eq("s2_in_ready_pop", 32'(in_ready), 32'd0);
      check_eq("s2_we3_w1", 32'(we3), 32'd1);
      check_eq("s2_a3_w1", 32'(a3), 32'd1);
      check_eq("s2_wd3_w1", wd3, 32'hA1);
      tick();
      in_valid = 1'b0;
      in_rd    = 5'd0;
      in_data  = 32'd0;
      check_eq("s2_count_after_pop", 32'(count), 32'd3);
      for (int i = 2; i <= 4; i++) begin
         check_eq("s2_we3_wn", 32'(we3), 32'd1);
         check_eq("s2_a3_wn", 32'(a3), 32'(i));
         check_eq("s2_wd3_wn", wd3, 32'hA0 + 32'(i));
         tick();
      end
      check_eq("s2_count_empty", 32'(count), 32'd0);
      check_eq("s2_we3_empty", 32'(we3), 32'd0);

      // r0 writeback: handshake completes, discarded
      in_valid = 1'b1;
      in_rd    = 5'd0;
      in_data  = 32'hFF;
      #1;
      check_eq("s3_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = 32'd0;
      check_eq("s3_count", 32'(count), 32'd0);
      check_eq("s3_we3", 32'(we3), 32'd0);
      tick();
      check_eq("s3_we3_later", 32'(we3), 32'd0);

      // Bypass lookup, then duplicate-rd drain order
      hold = 1'b1;
      push(5'd7, 32'h1);
      push(5'd7, 32'h2);
      a1 = 5'd7;
      a2 = 5'd0;
      #1;
`ifdef RF_WB_BYPASS_EN
      check_eq("s4_fwd1_hit", 32'(fwd1_hit), 32'd1);
      check_eq("s4_fwd1_data", fwd1_data, 32'h2);
`else
      check_eq("s4_fwd1_hit", 32'(fwd1_hit), 32'd0);
      check_eq("s4_fwd1_data", fwd1_data, 32'h0);
`endif
      check_eq("s4_fwd2_hit", 32'(fwd2_hit), 32'd0);
      check_eq("s4_fwd2_data", fwd2_data, 32'h0);
      a1 = 5'd5;
      #1;
      check_eq("s4_fwd1_miss", 32'(fwd1_hit), 32'd0);
      a1 = 5'd0;
      hold = 1'b0;
      #1;
      check_eq("s4_dup_a3_1", 32'(a3), 32'd7);
      check_eq("s4_dup_wd3_1", wd3, 32'h1);
      tick();
      check_eq("s4_dup_a3_2", 32'(a3), 32'd7);
      check_eq("s4_dup_wd3_2", wd3, 32'h2);
      tick();
      check_eq("s4_count", 32'(count), 32'd0);

      // Mid-operation reset discards pending entries
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         push(5'(8 + i), 32'hC0 + 32'(i));
      end
      check_eq("s5_count_full", 32'(count), 32'd4);
      rst_n = 1'b0;
      #1;
      check_eq("s5_rst_count", 32'(count), 32'd0);
      check_eq("s5_rst_we3", 32'(we3), 32'd0);
      check_eq("s5_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("s5_rst_a3", 32'(a3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hold  = 1'b0;
      #1;
      check_eq("s5_no_stale_we3", 32'(we3), 32'd0);
      tick();
      check_eq("s5_no_stale_we3_edge", 32'(we3), 32'd0);
      check_eq("s5_count_after", 32'(count), 32'd0);

      // Streaming: push every cycle, drained every cycle, pointers wrap
      hold = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1;
         in_rd    = 5'(i);
         in_data  = 32'h100 + 32'(i);
         tick();
         check_eq("s6_count", 32'(count), 32'd1);
         check_eq("s6_a3", 32'(a3), 32'(i));
         check_eq("s6_wd3", wd3, 32'h100 + 32'(i));
         check_eq("s6_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      in_rd    = 5'd0;
      in_data  = 32'd0;
      tick();
      check_eq("s6_count_end", 32'(count), 32'd0);
      check_eq("s6_we3_end", 32'(we3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
